// File: rtl/cpu_dbg_pkg.sv
// Shared types and width helpers for the CPU run-control / state-dump engine.
package cpu_dbg_pkg;

    // IDLE: waiting for start | RUN: core enabled | RD_ISSUE/RD_WAIT: sync read in flight
    // OUT: word offered to consumer | DONE: dump finished, results held
    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic DUMP_REG = 1'b0;
    localparam logic DUMP_MEM = 1'b1;

    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/halt_detector.sv
// Flags a halted core: pc unchanged for HALT_STABLE consecutive enabled cycles.
module halt_detector
    import cpu_dbg_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int HALT_STABLE = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clear,
    input  logic            i_en,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_halted
);

    localparam int SW = clog2_min1(HALT_STABLE + 1);
    localparam logic [SW-1:0] SW_MAX = '1;

    logic [XLEN-1:0] r_prev_pc;
    logic            r_prev_valid;
    logic [SW-1:0]   r_stable_cnt;
    logic            w_same;

    assign w_same = r_prev_valid && (i_pc == r_prev_pc);

    // Fires in the cycle whose compare brings the equal-pc run to HALT_STABLE-1.
    assign o_halted = i_en && w_same && (r_stable_cnt == SW'(HALT_STABLE - 2));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev_pc    <= '0;
            r_prev_valid <= 1'b0;
            r_stable_cnt <= '0;
        end else if (i_clear) begin
            r_prev_valid <= 1'b0;
            r_stable_cnt <= '0;
        end else if (i_en) begin
            r_prev_pc    <= i_pc;
            r_prev_valid <= 1'b1;
            if (w_same) begin
                if (r_stable_cnt != SW_MAX) r_stable_cnt <= r_stable_cnt + SW'(1);
            end else begin
                r_stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cpu_run_dump_ctrl.sv
// Runs a core until halt or timeout, then streams its registers and data memory
// over a valid/ready port.
module cpu_run_dump_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NREGS          = 32,
    parameter int DMEM_DEPTH     = 1024,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int HALT_STABLE    = 4,
    parameter int CW             = clog2_min1(TIMEOUT_CYCLES + 1),
    parameter int IW             = clog2_min1(max2(NREGS, DMEM_DEPTH))
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_cpu_run,
    output logic [IW-1:0]   o_reg_rd_addr,
    input  logic [XLEN-1:0] i_reg_rd_data,
    output logic [IW-1:0]   o_mem_rd_addr,
    input  logic [XLEN-1:0] i_mem_rd_data,
    output logic            o_dump_valid,
    input  logic            i_dump_ready,
    output logic [XLEN-1:0] o_dump_data,
    output logic            o_dump_is_mem,
    output logic [IW-1:0]   o_dump_index,
    output logic            o_done,
    output logic            o_timed_out,
    output logic [CW-1:0]   o_cycle_count
);

    localparam logic            HAS_MEM  = (DMEM_DEPTH > 0);
    localparam logic [CW-1:0]   CW_MAX   = '1;
    localparam logic [IW-1:0]   LAST_REG = IW'(NREGS - 1);
    localparam logic [IW-1:0]   LAST_MEM = IW'((DMEM_DEPTH > 0) ? DMEM_DEPTH - 1 : 0);

    state_t          r_state;
    logic            r_cpu_run;
    logic [IW-1:0]   r_reg_rd_addr;
    logic [IW-1:0]   r_mem_rd_addr;
    logic            r_dump_valid;
    logic [XLEN-1:0] r_dump_data;
    logic            r_dump_is_mem;
    logic [IW-1:0]   r_dump_index;
    logic            r_done;
    logic            r_timed_out;
    logic [CW-1:0]   r_cycle_count;
    logic            r_src;
    logic [IW-1:0]   r_index;

    logic            w_run;
    logic            w_start_ok;
    logic            w_halt;
    logic            w_timeout;
    logic [IW-1:0]   w_next_index;

    assign w_run        = (r_state == S_RUN);
    assign w_start_ok   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_timeout    = w_run && (r_cycle_count == CW'(TIMEOUT_CYCLES - 1));
    assign w_next_index = r_index + IW'(1);

    halt_detector #(
        .XLEN        (XLEN),
        .HALT_STABLE (HALT_STABLE)
    ) u_halt_detector (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_start_ok),
        .i_en     (w_run),
        .i_pc     (i_pc),
        .o_halted (w_halt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_cpu_run     <= 1'b0;
            r_reg_rd_addr <= '0;
            r_mem_rd_addr <= '0;
            r_dump_valid  <= 1'b0;
            r_dump_data   <= '0;
            r_dump_is_mem <= 1'b0;
            r_dump_index  <= '0;
            r_done        <= 1'b0;
            r_timed_out   <= 1'b0;
            r_cycle_count <= '0;
            r_src         <= DUMP_REG;
            r_index       <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state       <= S_RUN;
                        r_cpu_run     <= 1'b1;
                        r_done        <= 1'b0;
                        r_timed_out   <= 1'b0;
                        r_cycle_count <= '0;
                    end
                end
                S_RUN: begin
                    if (r_cycle_count != CW_MAX) r_cycle_count <= r_cycle_count + CW'(1);
                    if (w_halt || w_timeout) begin
                        r_cpu_run     <= 1'b0;
                        r_timed_out   <= !w_halt;
                        r_state       <= S_RD_ISSUE;
                        r_src         <= DUMP_REG;
                        r_index       <= '0;
                        r_reg_rd_addr <= '0;
                    end
                end
                S_RD_ISSUE: begin
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    r_dump_data   <= (r_src == DUMP_MEM) ? i_mem_rd_data : i_reg_rd_data;
                    r_dump_is_mem <= r_src;
                    r_dump_index  <= r_index;
                    r_dump_valid  <= 1'b1;
                    r_state       <= S_OUT;
                end
                S_OUT: begin
                    if (i_dump_ready) begin
                        r_dump_valid <= 1'b0;
                        if ((r_src == DUMP_REG) && (r_index == LAST_REG)) begin
                            if (HAS_MEM) begin
                                r_src         <= DUMP_MEM;
                                r_index       <= '0;
                                r_mem_rd_addr <= '0;
                                r_state       <= S_RD_ISSUE;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end else if ((r_src == DUMP_MEM) && (r_index == LAST_MEM)) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_index <= w_next_index;
                            if (r_src == DUMP_REG) r_reg_rd_addr <= w_next_index;
                            else                   r_mem_rd_addr <= w_next_index;
                            r_state <= S_RD_ISSUE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cpu_run     = r_cpu_run;
    assign o_reg_rd_addr = r_reg_rd_addr;
    assign o_mem_rd_addr = r_mem_rd_addr;
    assign o_dump_valid  = r_dump_valid;
    assign o_dump_data   = r_dump_data;
    assign o_dump_is_mem = r_dump_is_mem;
    assign o_dump_index  = r_dump_index;
    assign o_done        = r_done;
    assign o_timed_out   = r_timed_out;
    assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_cpu_run_dump_ctrl.sv
// Directed bench for cpu_run_dump_ctrl: halt, timeout, dump ordering, backpressure, reset, restart.
module tb_cpu_run_dump_ctrl;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int DMEM = 8;
    localparam int IW = 5;
    localparam int CW = 10;
    localparam int NW = NREGS + DMEM;

    logic            i_clk;
    logic            i_rst;
    logic            i_start;
    logic [XLEN-1:0] i_pc;
    logic            o_cpu_run;
    logic [IW-1:0]   o_reg_rd_addr;
    logic [XLEN-1:0] i_reg_rd_data;
    logic [IW-1:0]   o_mem_rd_addr;
    logic [XLEN-1:0] i_mem_rd_data;
    logic            o_dump_valid;
    logic            i_dump_ready;
    logic [XLEN-1:0] o_dump_data;
    logic            o_dump_is_mem;
    logic [IW-1:0]   o_dump_index;
    logic            o_done;
    logic            o_timed_out;
    logic [CW-1:0]   o_cycle_count;

    int n_cmp = 0;
    int n_err = 0;
    int en_cnt = 0;
    bit mode_inc = 1'b0;
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] mem  [DMEM];

    cpu_run_dump_ctrl #(
        .XLEN           (XLEN),
        .NREGS          (NREGS),
        .DMEM_DEPTH     (DMEM),
        .TIMEOUT_CYCLES (1000),
        .HALT_STABLE    (4)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_pc          (i_pc),
        .o_cpu_run     (o_cpu_run),
        .o_reg_rd_addr (o_reg_rd_addr),
        .i_reg_rd_data (i_reg_rd_data),
        .o_mem_rd_addr (o_mem_rd_addr),
        .i_mem_rd_data (i_mem_rd_data),
        .o_dump_valid  (o_dump_valid),
        .i_dump_ready  (i_dump_ready),
        .o_dump_data   (o_dump_data),
        .o_dump_is_mem (o_dump_is_mem),
        .o_dump_index  (o_dump_index),
        .o_done        (o_done),
        .o_timed_out   (o_timed_out),
        .o_cycle_count (o_cycle_count)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // CPU model: en_cnt is the number of enabled cycles already executed in this run.
    always @(posedge i_clk) en_cnt <= o_cpu_run ? en_cnt + 1 : 0;

    always_comb begin
        if (mode_inc) i_pc = 32'(en_cnt * 4);
        else          i_pc = (en_cnt < 9) ? 32'(32'h100 + en_cnt * 4) : 32'h20;
    end

    always @(posedge i_clk) begin
        i_reg_rd_data <= regs[o_reg_rd_addr];
        i_mem_rd_data <= mem[o_mem_rd_addr[2:0]];
    end

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_data(input int k);
        if (k < NREGS) return 32'(k * 3);
        return 32'(-(k - NREGS));
    endfunction

    task automatic pulse_start;
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic run_wait(input bit poke, output int cyc);
        cyc = 0;
        while (o_cpu_run === 1'b1 && cyc < 1200) begin
            i_start = poke && (cyc == 500);
            cyc++;
            @(negedge i_clk);
        end
        i_start = 1'b0;
        chk("run_stopped", 32'(o_cpu_run), 32'd0);
    endtask

    task automatic consume(input bit rnd, input bit poke, input int stop_at);
        int k;
        int cyc;
        int last_acc;
        bit pend;
        logic [XLEN-1:0] h_data;
        logic [IW-1:0]   h_idx;
        logic            h_mem;
        k = 0; cyc = 0; last_acc = 0; pend = 1'b0;
        h_data = '0; h_idx = '0; h_mem = 1'b0;
        while (k < NW && cyc < 3000) begin
            @(negedge i_clk);
            cyc++;
            i_start = poke && (cyc == 20);
            if (pend) begin
                chk("hold_valid", 32'(o_dump_valid), 32'd1);
                chk("hold_data", o_dump_data, h_data);
                chk("hold_index", 32'(o_dump_index), 32'(h_idx));
                chk("hold_is_mem", 32'(o_dump_is_mem), 32'(h_mem));
            end
            i_dump_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (o_dump_valid) begin
                if (k == stop_at) begin
                    i_dump_ready = 1'b0;
                    i_start = 1'b0;
                    return;
                end
                if (i_dump_ready) begin
                    chk($sformatf("w%0d_data", k), o_dump_data, exp_data(k));
                    chk($sformatf("w%0d_index", k), 32'(o_dump_index), 32'((k < NREGS) ? k : k - NREGS));
                    chk($sformatf("w%0d_is_mem", k), 32'(o_dump_is_mem), 32'(k >= NREGS));
                    if (!rnd && k > 0) chk($sformatf("w%0d_gap", k), 32'(cyc - last_acc), 32'd3);
                    last_acc = cyc;
                    k++;
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    h_data = o_dump_data;
                    h_idx = o_dump_index;
                    h_mem = o_dump_is_mem;
                end
            end
        end
        i_start = 1'b0;
        chk("dump_words", 32'(k), 32'(NW));
        @(negedge i_clk);
        i_dump_ready = 1'b0;
        chk("dump_done", 32'(o_done), 32'd1);
        chk("dump_valid_low", 32'(o_dump_valid), 32'd0);
        chk("dump_cpu_run_low", 32'(o_cpu_run), 32'd0);
    endtask

    initial begin
        int cyc;
        i_rst = 1'b1;
        i_start = 1'b0;
        i_dump_ready = 1'b0;
        for (int i = 0; i < NREGS; i++) regs[i] = 32'(i * 3);
        for (int j = 0; j < DMEM; j++) mem[j] = 32'(-j);

        repeat (3) @(negedge i_clk);
        chk("rst_cpu_run", 32'(o_cpu_run), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_valid", 32'(o_dump_valid), 32'd0);
        chk("rst_timed_out", 32'(o_timed_out), 32'd0);
        chk("rst_cycle_count", 32'(o_cycle_count), 32'd0);
        chk("rst_reg_addr", 32'(o_reg_rd_addr), 32'd0);
        i_rst = 1'b0;

        // Halt: self-jump at 0x20 from cycle 10; full dump with ready held high.
        mode_inc = 1'b0;
        pulse_start();
        chk("t1_cpu_run_on", 32'(o_cpu_run), 32'd1);
        chk("t1_cc_first", 32'(o_cycle_count), 32'd0);
        run_wait(1'b0, cyc);
        chk("t1_run_cycles", 32'(cyc), 32'd13);
        chk("t1_cycle_count", 32'(o_cycle_count), 32'd13);
        chk("t1_timed_out", 32'(o_timed_out), 32'd0);
        consume(1'b0, 1'b0, -1);
        chk("t1_cc_frozen", 32'(o_cycle_count), 32'd13);
        chk("t1_timed_out_done", 32'(o_timed_out), 32'd0);

        // Restart from DONE, timeout run with start poked mid-run and mid-dump, random ready.
        mode_inc = 1'b1;
        pulse_start();
        chk("t6_restart_cc", 32'(o_cycle_count), 32'd0);
        chk("t6_restart_done", 32'(o_done), 32'd0);
        chk("t6_restart_to", 32'(o_timed_out), 32'd0);
        run_wait(1'b1, cyc);
        chk("t2_run_cycles", 32'(cyc), 32'd1000);
        chk("t2_cycle_count", 32'(o_cycle_count), 32'd1000);
        chk("t2_timed_out", 32'(o_timed_out), 32'd1);
        consume(1'b1, 1'b1, -1);
        chk("t2_timed_out_done", 32'(o_timed_out), 32'd1);

        // Reset while reg 7 is being offered, then a clean full run.
        mode_inc = 1'b0;
        pulse_start();
        run_wait(1'b0, cyc);
        consume(1'b0, 1'b0, 7);
        chk("t5_at_reg7", 32'(o_dump_index), 32'd7);
        #2 i_rst = 1'b1;
        #1;
        chk("t5_cpu_run", 32'(o_cpu_run), 32'd0);
        chk("t5_valid", 32'(o_dump_valid), 32'd0);
        chk("t5_data", o_dump_data, 32'd0);
        chk("t5_index", 32'(o_dump_index), 32'd0);
        chk("t5_is_mem", 32'(o_dump_is_mem), 32'd0);
        chk("t5_done", 32'(o_done), 32'd0);
        chk("t5_cycle_count", 32'(o_cycle_count), 32'd0);
        chk("t5_reg_addr", 32'(o_reg_rd_addr), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("t5_idle_valid", 32'(o_dump_valid), 32'd0);
        pulse_start();
        run_wait(1'b0, cyc);
        chk("t5_run_cycles", 32'(cyc), 32'd13);
        consume(1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
